// File: rtl/hwpe_multi_stream_engine_ctrl.sv
// Engine-side controller for an HWPE kernel with N_OUT output streams.
// Launches the kernel, counts accepted beats per stream against lengths latched
// at start, and emits a one-cycle done once every stream and the kernel are done.
// Optional stall watchdog: define HWPE_ENGINE_WATCHDOG_EN.
module hwpe_multi_stream_engine_ctrl #(
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WDOG_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [N_OUT*CNT_W-1:0] len_i,
    input  logic [N_OUT-1:0]       out_valid_i,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic                   k_start_o,
    input  logic                   k_done_i,
    input  logic                   k_idle_i,
    input  logic                   k_ready_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_OUT*CNT_W-1:0] cnt_o,
    output logic [N_OUT-1:0]       ovf_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [N_OUT*CNT_W-1:0] len_q, len_d;
    logic [N_OUT*CNT_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]       ovf_q, ovf_d;
    logic                   kdone_q, kdone_d;
    logic                   kstart_q, kstart_d;
    logic                   ready_q, ready_d;
    logic [N_OUT-1:0]       beat, cmpl;
    logic                   finish;
`ifdef HWPE_ENGINE_WATCHDOG_EN
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;
`endif

    // Per-stream handshake detection and completion against the latched length.
    always_comb begin
        beat = out_valid_i & out_ready_i;
        for (int k = 0; k < int'(N_OUT); k++) begin
            cmpl[k] = (cnt_q[k*CNT_W +: CNT_W] == len_q[k*CNT_W +: CNT_W]);
        end
        // Kernel done may arrive as a pulse in this very cycle or earlier (sticky).
        finish = (&cmpl) & (kdone_q | k_done_i);
    end

    // Next-state logic: job sequencing, beat counting, overflow and watchdog.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        kdone_d  = kdone_q;
        kstart_d = 1'b0;
`ifdef HWPE_ENGINE_WATCHDOG_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i && ready_q) begin
                    state_d  = StRun;
                    len_d    = len_i;
                    cnt_d    = '0;
                    ovf_d    = '0;
                    kdone_d  = 1'b0;
                    kstart_d = 1'b1;
`ifdef HWPE_ENGINE_WATCHDOG_EN
                    wdog_d   = '0;
`endif
                end
            end
            StRun: begin
                if (k_done_i) kdone_d = 1'b1;
                for (int k = 0; k < int'(N_OUT); k++) begin
                    if (beat[k]) begin
                        // Saturate at the expected length; extra beats flag overflow.
                        if (!cmpl[k]) cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
                        else          ovf_d[k] = 1'b1;
                    end
                end
                if (finish) state_d = StDone;
`ifdef HWPE_ENGINE_WATCHDOG_EN
                if ((|beat) || k_done_i) wdog_d = '0;
                else                     wdog_d = wdog_q + WDOG_W'(1);
                // A completing job always wins over a simultaneous stall timeout.
                if (!finish && (wdog_d == {WDOG_W{1'b1}})) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
`endif
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (clear_i) begin
            state_d  = StIdle;
            len_d    = '0;
            cnt_d    = '0;
            ovf_d    = '0;
            kdone_d  = 1'b0;
            kstart_d = 1'b0;
`ifdef HWPE_ENGINE_WATCHDOG_EN
            wdog_d    = '0;
            timeout_d = 1'b0;
`endif
        end

        // Clear behaves like reset for ready; it is re-evaluated on the following cycle.
        ready_d = !clear_i && (state_d == StIdle) && (k_ready_i || k_idle_i);
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
            kdone_q  <= 1'b0;
            kstart_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            kdone_q  <= kdone_d;
            kstart_q <= kstart_d;
            ready_q  <= ready_d;
        end
    end

`ifdef HWPE_ENGINE_WATCHDOG_EN
    // Stall watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign k_start_o = kstart_q;
    assign ready_o   = ready_q;
    assign busy_o    = (state_q == StRun);
    assign done_o    = (state_q == StDone);
    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_hwpe_multi_stream_engine_ctrl.sv
// Self-checking bench for hwpe_multi_stream_engine_ctrl: directed scenarios plus
// random traffic, all compared every cycle against a behavioural job model.
module tb_hwpe_multi_stream_engine_ctrl;

    localparam int unsigned N      = 2;
    localparam int unsigned CW     = 8;
    localparam int unsigned WW     = 4;
    localparam int          WD_MAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0, start = 1'b0, k_done = 1'b0;
    logic          k_idle = 1'b0, k_ready = 1'b0;
    logic [N*CW-1:0] len_in = '0;
    logic [N-1:0]  vld = '0, rdy = '0;
    logic          k_start, ready, busy, done, timeout;
    logic [N*CW-1:0] cnt;
    logic [N-1:0]  ovf;

    int n_vec = 0;
    int n_err = 0;

    // Model of the job: phase 0 idle, 1 running, 2 completing.
    int m_phase;
    int m_len[N];
    int m_cnt[N];
    bit m_ovf[N];
    bit m_kd, m_kstart, m_ready, m_tmo;
    int m_stall;

    always #5 clk = ~clk;

    hwpe_multi_stream_engine_ctrl #(.N_OUT(N), .CNT_W(CW), .WDOG_W(WW)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .len_i(len_in),
        .out_valid_i(vld), .out_ready_i(rdy), .k_start_o(k_start), .k_done_i(k_done),
        .k_idle_i(k_idle), .k_ready_i(k_ready), .ready_o(ready), .busy_o(busy),
        .done_o(done), .cnt_o(cnt), .ovf_o(ovf), .timeout_o(timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_phase = 0; m_kd = 0; m_kstart = 0; m_ready = 0; m_tmo = 0; m_stall = 0;
        for (int k = 0; k < N; k++) begin m_len[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; end
    endtask

    task automatic compare_all();
        check("busy", {63'd0, busy}, {63'd0, m_phase == 1});
        check("done", {63'd0, done}, {63'd0, m_phase == 2});
        check("k_start", {63'd0, k_start}, {63'd0, m_kstart});
        check("ready", {63'd0, ready}, {63'd0, m_ready});
        check("timeout", {63'd0, timeout}, {63'd0, m_tmo});
        for (int k = 0; k < N; k++) begin
            check($sformatf("cnt%0d", k), {56'd0, cnt[k*CW +: CW]}, 64'(m_cnt[k]));
            check($sformatf("ovf%0d", k), {63'd0, ovf[k]}, {63'd0, m_ovf[k]});
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit all_done, fin, any;
        m_kstart = 0;
        m_tmo    = 0;
        if (clear) begin
            model_zero();
            return;
        end
        case (m_phase)
            0: if (start && m_ready) begin
                m_phase = 1; m_kd = 0; m_kstart = 1; m_stall = 0;
                for (int k = 0; k < N; k++) begin
                    m_len[k] = int'(len_in[k*CW +: CW]); m_cnt[k] = 0; m_ovf[k] = 0;
                end
            end
            1: begin
                all_done = 1; any = 0;
                for (int k = 0; k < N; k++) if (m_cnt[k] != m_len[k]) all_done = 0;
                fin = all_done && (m_kd || k_done);
                for (int k = 0; k < N; k++) begin
                    if (vld[k] && rdy[k]) begin
                        any = 1;
                        if (m_cnt[k] < m_len[k]) m_cnt[k]++;
                        else m_ovf[k] = 1;
                    end
                end
                if (k_done) m_kd = 1;
                if (fin) m_phase = 2;
`ifdef HWPE_ENGINE_WATCHDOG_EN
                m_stall = (any || k_done) ? 0 : m_stall + 1;
                if (!fin && m_stall == WD_MAX) begin m_phase = 0; m_tmo = 1; end
`endif
            end
            default: m_phase = 0;
        endcase
        m_ready = (m_phase == 0) && (k_ready || k_idle);
    endtask

    task automatic cyc(input logic st, input logic clr, input logic kd,
                       input logic [N-1:0] v, input logic [N-1:0] r);
        start = st; clear = clr; k_done = kd; vld = v; rdy = r;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle, then released with the kernel idle.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_cnt", {48'd0, cnt}, 64'd0);
        check("rst_ovf", {62'd0, ovf}, 64'd0);
        check("rst_kstart", {63'd0, k_start}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        model_zero();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_zero();
        k_idle = 1'b1;
        k_ready = 1'b1;
        #12;
        mid_reset();
        idle(2);

        // Two streams {4,2}; kernel done arrives before the final beat.
        len_in = {8'd2, 8'd4};
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b01);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        idle(4);
        check("jobA_cnt", {48'd0, cnt}, 64'h0204);
        check("jobA_ovf", {62'd0, ovf}, 64'd0);

        // {3,0}: five beats on stream 0 saturate at 3 and flag overflow.
        len_in = {8'd0, 8'd3};
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, '0, '0);
        idle(3);
        check("jobB_cnt", {48'd0, cnt}, 64'h0003);
        check("jobB_ovf", {62'd0, ovf}, 64'h1);

        // Clear in RUN together with a beat.
        len_in = {8'd4, 8'd4};
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
        cyc(1'b0, 1'b1, 1'b1, 2'b11, 2'b11);
        check("clr_cnt", {48'd0, cnt}, 64'd0);
        idle(2);

        // Start held high across whole jobs.
        len_in = {8'd1, 8'd1};
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b1, 2'b11, 2'b11);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 5), (i == 5) ? 2'b11 : 2'b00, 2'b11);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        idle(2);

        // Stalled job: watchdog fires if enabled, otherwise RUN persists.
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        idle(20);
        mid_reset();
        idle(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 0)
                for (int k = 0; k < N; k++) len_in[k*CW +: CW] = 8'($urandom_range(0, 5));
            k_idle  = ($urandom_range(0, 3) != 0);
            k_ready = ($urandom_range(0, 1) != 0);
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0),
                ($urandom_range(0, 7) == 0), N'($urandom), N'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_multi_stream_engine_ctrl.md
Name: hwpe_multi_stream_engine_ctrl

Overview:
Parametrised engine-side controller for HWPE accelerators with N_OUT output streams. It launches the kernel and taps each output stream's valid/ready handshake. It counts accepted beats per stream against lengths latched at start and raises a one-cycle done once every stream is complete and the kernel reports done. It sits between the HWPE controller FSM (ctrl/flags) and the kernel adapter, replacing single-stream, unbounded beat counting.

Parameters:
N_OUT, 2, number of monitored output streams (1..8)
CNT_W, 32, width of each beat counter and length field
WDOG_W, 16, watchdog counter width (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous soft clear from controller
start_i  in  1  job start request (level sampled only in IDLE)
len_i  in  N_OUT*CNT_W  expected beats per stream; stream k at [k*CNT_W +: CNT_W]
out_valid_i  in  N_OUT  tapped valid of each output stream
out_ready_i  in  N_OUT  tapped ready of each output stream
k_start_o  out  1  one-cycle kernel start pulse
k_done_i  in  1  kernel done (pulse or level)
k_idle_i  in  1  kernel idle
k_ready_i  in  1  kernel ready
ready_o  out  1  engine ready for new job (registered)
busy_o  out  1  high in RUN
done_o  out  1  one-cycle job-complete pulse
cnt_o  out  N_OUT*CNT_W  accepted-beat count per stream
ovf_o  out  N_OUT  sticky: stream k saw a beat after reaching its length
timeout_o  out  1  one-cycle watchdog pulse (optional feature)

Behaviour:
- Reset and interface: one clock, clk_i. Reset rst_i is asynchronous and active-high. Under reset: state IDLE, all counters 0, len registers 0, done sticky 0. All outputs are 0, including ready_o.
- clear_i: synchronous. Priority over every event except reset. Same effect as reset, except ready_o is re-evaluated on the next cycle. No done_o is emitted when clear_i aborts a RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start_i & ready_o.
  - On this transition: latch len_i, zero cnt_o and ovf_o, zero the done sticky.
  - k_start_o is high exactly in the first RUN cycle.
- RUN: beat on stream k when out_valid_i[k] & out_ready_i[k] in the same cycle. cnt_o[k] increments in the next cycle.
  - Once cnt_o[k] == len[k], further beats do not increment the counter. They set ovf_o[k] (sticky until next start or clear).
  - Stream k is complete when cnt_o[k] == len[k]; len 0 is complete immediately.
  - k_done_i sets the done sticky.
- RUN -> DONE when all streams are complete (registered counts) and the done sticky is set, or k_done_i is high in that cycle.
  - Latency: last beat at cycle t -> cnt updated t+1 -> done_o high at t+2, provided kernel done has already arrived.
- DONE: done_o = 1 for exactly one cycle, then IDLE. Counts hold until the next start or clear.
- start_i in RUN or DONE is ignored, with no queuing.
- busy_o = (state == RUN).
- ready_o is a registered flag: next value = (state_next == IDLE) & (k_ready_i | k_idle_i). It is 0 during RUN and DONE.
- Simultaneous events:
  - clear_i together with a beat: the clear wins and the count stays 0.
  - A beat together with start_i in IDLE: the beat is not counted.
  - k_done_i before all beats: the engine waits in RUN for the remaining beats.
- Counters never wrap.

Optional Feature:
- Macro: HWPE_ENGINE_WATCHDOG_EN.
- When defined:
  - A WDOG_W-bit counter runs in RUN and resets to 0 on any beat, on k_done_i, and on entry to RUN.
  - When it reaches all-ones: timeout_o pulses for one cycle, the FSM goes to IDLE, and done_o stays 0. Counts and ovf_o are held for debug.
- When undefined: no watchdog logic; timeout_o is tied to 0 and a stalled job stays in RUN until clear_i or reset.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately. After release with k_idle_i=1, ready_o=1 one cycle later.
- Two streams, len {4,2}, 4 and 2 beats, k_done_i pulsed before the last beat -> k_start_o one pulse. Final cnt_o {4,2} and ovf_o=00. done_o is a single pulse 2 cycles after the last beat.
- len {3,0}, 5 beats on stream 0 -> cnt_o[0]=3, ovf_o[0]=1, cnt_o[1]=0. done_o after k_done_i.
- clear_i asserted in RUN on the same cycle as a beat (cnt 2/4) -> cnt_o=0, state IDLE, no done_o. ready_o returns 1 next cycle.
- start_i held high through RUN and DONE -> exactly one job. A second job starts only after ready_o re-asserts, with k_start_o pulsing once per job.
- With HWPE_ENGINE_WATCHDOG_EN and WDOG_W=4, no beats after start -> timeout_o pulses 15 cycles after entering RUN, then the FSM is in IDLE and done_o never asserts. Without the macro, the same stimulus leaves busy_o=1 indefinitely.
